// File: rtl/p2_video_scan.sv
// p2_video_scan: raster scan-out controller for the 1152x900 monochrome
// framebuffer. Owns VRAM read port 1, generates H/V timing, fetches one
// 16-bit word every 16 pixels and serializes it MSB-first into a 1-bit
// pixel stream. Sync, blank and frame_start are pipelined alongside the
// pixel data so that every output lags the counter state by two clocks.
module p2_video_scan #(
  parameter int H_ACTIVE = 1152,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 208,
  parameter int V_ACTIVE = 900,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        invert,
  output logic [16:0] vram_addr,
  output logic        vram_en,
  input  logic [15:0] vram_data,
  output logic        pixel,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FRONT);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FRONT);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // run_q marks that scanning is live; the first enabled edge only arms it,
  // so the counters are still at 0 in the first enabled cycle.
  logic           run_q, run_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic [16:0]    addr_q, addr_d;

  // Stage 1: decoded timing and the "load the shifter" flag for the word
  // returned by VRAM one cycle after the fetch.
  logic ld_q, ld_d;
  logic blank1_q, blank1_d;
  logic hs1_q, hs1_d;
  logic vs1_q, vs1_d;
  logic fs1_q, fs1_d;

  // Stage 2: registered outputs plus the pixel shifter.
  logic [15:0] shift_q, shift_d;
  logic pixel_q, pixel_d;
  logic hs2_q, hs2_d;
  logic vs2_q, vs2_d;
  logic blank2_q, blank2_d;
  logic fs2_q, fs2_d;

  logic h_last;
  logic v_last;
  logic active;
  logic fetch;
  logic in_hsync;
  logic in_vsync;

  // Decode the current raster position into visible area, fetch slot and sync windows.
  always_comb begin
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    active   = run_q && (h_q < H_ACT) && (v_q < V_ACT);
    fetch    = active && (h_q[3:0] == 4'd0);
    in_hsync = run_q && (h_q >= HS_START) && (h_q < HS_END);
    in_vsync = run_q && (v_q >= VS_START) && (v_q < VS_END);
  end

  // Advance the raster counters and the fetch address; disabling clears everything.
  always_comb begin
    run_d  = enable;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (!enable || !run_q) begin
      h_d    = '0;
      v_d    = '0;
      addr_d = '0;
    end else begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
      end
      if (fetch) begin
        addr_d = addr_q + 17'd2;
      end
      if (h_last && v_last) begin
        addr_d = '0;
      end
    end
  end

  // First pipeline stage: capture timing decode for the current position.
  always_comb begin
    ld_d     = 1'b0;
    blank1_d = 1'b0;
    hs1_d    = 1'b1;
    vs1_d    = 1'b1;
    fs1_d    = 1'b0;
    if (enable) begin
      ld_d     = fetch;
      blank1_d = active;
      hs1_d    = !in_hsync;
      vs1_d    = !in_vsync;
      fs1_d    = run_q && (h_q == '0) && (v_q == '0);
    end
  end

  // Second stage: load or shift the pixel word and register the outputs.
  // The pixel is taken from the next shifter value so that a freshly loaded
  // word's MSB appears in the same cycle as its stage-2 blank/sync.
  always_comb begin
    shift_d  = '0;
    pixel_d  = 1'b0;
    hs2_d    = 1'b1;
    vs2_d    = 1'b1;
    blank2_d = 1'b0;
    fs2_d    = 1'b0;
    if (enable) begin
      shift_d  = ld_q ? vram_data : {shift_q[14:0], 1'b0};
      pixel_d  = blank1_q ? (shift_d[15] ^ invert) : 1'b0;
      hs2_d    = hs1_q;
      vs2_d    = vs1_q;
      blank2_d = blank1_q;
      fs2_d    = fs1_q;
    end
  end

  // Counter and address state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
    end else begin
      run_q  <= run_d;
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
    end
  end

  // First pipeline stage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_q     <= 1'b0;
      blank1_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      fs1_q    <= 1'b0;
    end else begin
      ld_q     <= ld_d;
      blank1_q <= blank1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      fs1_q    <= fs1_d;
    end
  end

  // Second pipeline stage registers, including the shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      pixel_q  <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      blank2_q <= 1'b0;
      fs2_q    <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      pixel_q  <= pixel_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      blank2_q <= blank2_d;
      fs2_q    <= fs2_d;
    end
  end

  assign vram_en     = fetch;
  assign vram_addr   = addr_q;
  assign pixel       = pixel_q;
  assign hsync_n     = hs2_q;
  assign vsync_n     = vs2_q;
  assign blank_n     = blank2_q;
  assign frame_start = fs2_q;

endmodule

// File: tb/tb_p2_video_scan.sv
// tb_p2_video_scan: directed bench for the raster scan-out controller.
// A full-size instance covers reset, serialization, per-line addressing and
// timing, enable drop and async reset; a shrunken instance covers the
// frame-level behaviour (vsync, frame wrap) in a few hundred cycles.
module tb_p2_video_scan;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        invert;

  logic [16:0] b_addr;
  logic        b_en;
  logic [15:0] b_data;
  logic        b_pixel, b_hs, b_vs, b_blank, b_fs;

  logic [16:0] s_addr;
  logic        s_en;
  logic [15:0] s_data;
  logic        s_pixel, s_hs, s_vs, s_blank, s_fs;

  int checks;
  int errors;

  p2_video_scan u_big (
    .clk(clk), .reset_n(reset_n), .enable(enable), .invert(invert),
    .vram_addr(b_addr), .vram_en(b_en), .vram_data(b_data),
    .pixel(b_pixel), .hsync_n(b_hs), .vsync_n(b_vs), .blank_n(b_blank),
    .frame_start(b_fs)
  );

  // Small raster: H_TOTAL = 48, V_TOTAL = 8, 2 fetches per line, stride 4 bytes.
  p2_video_scan #(
    .H_ACTIVE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .enable(enable), .invert(invert),
    .vram_addr(s_addr), .vram_en(s_en), .vram_data(s_data),
    .pixel(s_pixel), .hsync_n(s_hs), .vsync_n(s_vs), .blank_n(s_blank),
    .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [16:0] a);
    if (a == 17'd0) return 16'h8001;
    return a[16:1] ^ 16'hA5C3;
  endfunction

  // VRAM port 1 model: one-cycle read latency, junk outside the load cycle.
  always @(posedge clk) begin
    b_data <= b_en ? word_at(b_addr) : 16'hDEAD;
    s_data <= s_en ? word_at(s_addr) : 16'hDEAD;
  end

  // Pulse reset then release; returns at the negedge of the first enabled cycle (C0).
  task automatic start_scan(input logic inv);
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b1;
    invert  = inv;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    enable  = 1'b1;
    invert  = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b_en !== 1'b0) begin errors++; $display("FAIL reset_vram_en got %b exp 0", b_en); end
    checks++; if (b_hs !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", b_hs); end
    checks++; if (b_vs !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", b_vs); end
    checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", b_blank); end
    checks++; if (b_pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b exp 0", b_pixel); end
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", b_fs); end
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", b_addr); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (b_en !== 1'b1) begin errors++; $display("FAIL first_fetch_en got %b exp 1", b_en); end
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL first_fetch_addr got %h exp 0", b_addr); end
    @(negedge clk);
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL fs_early got %b exp 0", b_fs); end
    checks++; if (b_addr !== 17'h2) begin errors++; $display("FAIL addr_advance got %h exp 2", b_addr); end
    @(negedge clk);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL frame_start got %b exp 1", b_fs); end
    checks++; if (b_blank !== 1'b1) begin errors++; $display("FAIL first_blank got %b exp 1", b_blank); end
  endtask

  // Continues from C2 of test_reset: word 0x8001 emitted MSB first.
  task automatic test_serialization;
    logic exp;
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0 || i == 15);
      checks++; if (b_pixel !== exp) begin errors++; $display("FAIL serial_bit%0d got %b exp %b", i, b_pixel, exp); end
      @(negedge clk);
    end
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL fs_single got %b exp 0", b_fs); end
  endtask

  task automatic test_invert;
    logic exp;
    start_scan(1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      exp = !(i == 0 || i == 15);
      checks++; if (b_pixel !== exp) begin errors++; $display("FAIL invert_bit%0d got %b exp %b", i, b_pixel, exp); end
      @(negedge clk);
    end
    // now at C18; move to C1153 (output for h=1151, last visible pixel)
    repeat (1153 - 18) @(negedge clk);
    checks++; if (b_blank !== 1'b1) begin errors++; $display("FAIL last_visible_blank got %b exp 1", b_blank); end
    checks++; if (b_pixel !== 1'b1) begin errors++; $display("FAIL last_visible_pixel got %b exp 1", b_pixel); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL hblank%0d blank got %b exp 0", i, b_blank); end
      checks++; if (b_pixel !== 1'b0) begin errors++; $display("FAIL hblank%0d pixel got %b exp 0", i, b_pixel); end
    end
    invert = 1'b0;
  endtask

  task automatic test_line_timing;
    int fetches, hs_low, blank_hi, fall1, fall2;
    logic prev_hs;
    logic [16:0] addr_last0, addr_first1;
    logic en_first1;
    fetches = 0; hs_low = 0; blank_hi = 0; fall1 = -1; fall2 = -1;
    prev_hs = 1'b1; addr_last0 = '1; addr_first1 = '1; en_first1 = 1'b0;
    start_scan(1'b0);
    for (int c = 0; c < 2800; c++) begin
      if (c < 1528 && b_en) fetches++;
      if (c == 1136 && b_en) addr_last0 = b_addr;
      if (c == 1528) begin en_first1 = b_en; addr_first1 = b_addr; end
      if (c < 1530 && !b_hs) hs_low++;
      if (c < 1530 && b_blank) blank_hi++;
      if (prev_hs && !b_hs) begin
        if (fall1 < 0) fall1 = c; else if (fall2 < 0) fall2 = c;
      end
      prev_hs = b_hs;
      @(negedge clk);
    end
    checks++; if (fetches != 72) begin errors++; $display("FAIL fetches_per_line got %0d exp 72", fetches); end
    checks++; if (addr_last0 !== 17'h0008E) begin errors++; $display("FAIL line0_last_addr got %h exp 0008e", addr_last0); end
    checks++; if (en_first1 !== 1'b1) begin errors++; $display("FAIL line1_fetch_en got %b exp 1", en_first1); end
    checks++; if (addr_first1 !== 17'h00090) begin errors++; $display("FAIL line1_first_addr got %h exp 00090", addr_first1); end
    checks++; if (fall1 != 1194) begin errors++; $display("FAIL hsync_start got %0d exp 1194", fall1); end
    checks++; if (hs_low != 128) begin errors++; $display("FAIL hsync_width got %0d exp 128", hs_low); end
    checks++; if (fall2 - fall1 != 1528) begin errors++; $display("FAIL line_period got %0d exp 1528", fall2 - fall1); end
    checks++; if (blank_hi != 1152) begin errors++; $display("FAIL blank_width got %0d exp 1152", blank_hi); end
  endtask

  task automatic test_frame;
    int fetch_l0, fetch_f0, vs_low, blank_hi, hs_low, hfall1, hfall2, vfall, fs1, fs2;
    logic prev_hs, prev_vs;
    logic [16:0] last_addr, addr_l1, addr_wrap;
    logic en_wrap;
    fetch_l0 = 0; fetch_f0 = 0; vs_low = 0; blank_hi = 0; hs_low = 0;
    hfall1 = -1; hfall2 = -1; vfall = -1; fs1 = -1; fs2 = -1;
    prev_hs = 1'b1; prev_vs = 1'b1;
    last_addr = '1; addr_l1 = '1; addr_wrap = '1; en_wrap = 1'b0;
    start_scan(1'b0);
    for (int c = 0; c < 400; c++) begin
      if (c < 48 && s_en) fetch_l0++;
      if (c < 384 && s_en) begin fetch_f0++; last_addr = s_addr; end
      if (c == 48) addr_l1 = s_addr;
      if (c == 384) begin en_wrap = s_en; addr_wrap = s_addr; end
      if (c < 50 && !s_hs) hs_low++;
      if (c < 386 && !s_vs) vs_low++;
      if (c < 386 && s_blank) blank_hi++;
      if (prev_hs && !s_hs) begin
        if (hfall1 < 0) hfall1 = c; else if (hfall2 < 0) hfall2 = c;
      end
      if (prev_vs && !s_vs && vfall < 0) vfall = c;
      if (s_fs) begin
        if (fs1 < 0) fs1 = c; else if (fs2 < 0) fs2 = c;
      end
      prev_hs = s_hs;
      prev_vs = s_vs;
      @(negedge clk);
    end
    checks++; if (fetch_l0 != 2) begin errors++; $display("FAIL small_fetch_line got %0d exp 2", fetch_l0); end
    checks++; if (fetch_f0 != 8) begin errors++; $display("FAIL small_fetch_frame got %0d exp 8", fetch_f0); end
    checks++; if (addr_l1 !== 17'h4) begin errors++; $display("FAIL small_line1_addr got %h exp 4", addr_l1); end
    checks++; if (last_addr !== 17'hE) begin errors++; $display("FAIL small_last_addr got %h exp e", last_addr); end
    checks++; if (en_wrap !== 1'b1) begin errors++; $display("FAIL small_wrap_en got %b exp 1", en_wrap); end
    checks++; if (addr_wrap !== 17'h0) begin errors++; $display("FAIL small_wrap_addr got %h exp 0", addr_wrap); end
    checks++; if (hfall1 != 38) begin errors++; $display("FAIL small_hsync_start got %0d exp 38", hfall1); end
    checks++; if (hs_low != 8) begin errors++; $display("FAIL small_hsync_width got %0d exp 8", hs_low); end
    checks++; if (hfall2 != 86) begin errors++; $display("FAIL small_line_period got %0d exp 86", hfall2); end
    checks++; if (vfall != 242) begin errors++; $display("FAIL small_vsync_start got %0d exp 242", vfall); end
    checks++; if (vs_low != 96) begin errors++; $display("FAIL small_vsync_width got %0d exp 96", vs_low); end
    checks++; if (blank_hi != 128) begin errors++; $display("FAIL small_blank_total got %0d exp 128", blank_hi); end
    checks++; if (fs1 != 2) begin errors++; $display("FAIL small_fs_first got %0d exp 2", fs1); end
    checks++; if (fs2 != 386) begin errors++; $display("FAIL small_frame_period got %0d exp 386", fs2); end
  endtask

  task automatic test_enable_drop;
    start_scan(1'b0);
    repeat (15780) @(negedge clk);
    // line 10, h_cnt = 500: 32 fetches done on this line
    checks++; if (b_addr !== 17'h005E0) begin errors++; $display("FAIL drop_addr_before got %h exp 005e0", b_addr); end
    checks++; if (b_blank !== 1'b1) begin errors++; $display("FAIL drop_blank_before got %b exp 1", b_blank); end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (b_en !== 1'b0) begin errors++; $display("FAIL drop_en got %b exp 0", b_en); end
    checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL drop_blank got %b exp 0", b_blank); end
    checks++; if (b_hs !== 1'b1) begin errors++; $display("FAIL drop_hsync got %b exp 1", b_hs); end
    checks++; if (b_vs !== 1'b1) begin errors++; $display("FAIL drop_vsync got %b exp 1", b_vs); end
    checks++; if (b_pixel !== 1'b0) begin errors++; $display("FAIL drop_pixel got %b exp 0", b_pixel); end
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL drop_addr got %h exp 0", b_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b_en !== 1'b0) begin errors++; $display("FAIL idle%0d_en got %b exp 0", i, b_en); end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (b_en !== 1'b1) begin errors++; $display("FAIL restart_en got %b exp 1", b_en); end
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL restart_addr got %h exp 0", b_addr); end
    @(negedge clk);
    checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL restart_fs_early got %b exp 0", b_fs); end
    @(negedge clk);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL restart_fs got %b exp 1", b_fs); end
    checks++; if (b_pixel !== 1'b1) begin errors++; $display("FAIL restart_pixel got %b exp 1", b_pixel); end
  endtask

  task automatic test_async_reset;
    start_scan(1'b0);
    repeat (37) @(negedge clk);
    checks++; if (b_addr !== 17'h6) begin errors++; $display("FAIL midword_addr got %h exp 6", b_addr); end
    checks++; if (b_blank !== 1'b1) begin errors++; $display("FAIL midword_blank got %b exp 1", b_blank); end
    reset_n = 1'b0;
    #1;
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL async_addr got %h exp 0", b_addr); end
    checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL async_blank got %b exp 0", b_blank); end
    checks++; if (b_hs !== 1'b1) begin errors++; $display("FAIL async_hsync got %b exp 1", b_hs); end
    checks++; if (b_en !== 1'b0) begin errors++; $display("FAIL async_en got %b exp 0", b_en); end
    checks++; if (b_pixel !== 1'b0) begin errors++; $display("FAIL async_pixel got %b exp 0", b_pixel); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (b_en !== 1'b1) begin errors++; $display("FAIL post_reset_en got %b exp 1", b_en); end
    checks++; if (b_addr !== 17'h0) begin errors++; $display("FAIL post_reset_addr got %h exp 0", b_addr); end
    checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL post_reset_blank_c0 got %b exp 0", b_blank); end
    @(negedge clk);
    checks++; if (b_blank !== 1'b0) begin errors++; $display("FAIL post_reset_blank_c1 got %b exp 0", b_blank); end
    checks++; if (b_pixel !== 1'b0) begin errors++; $display("FAIL post_reset_pixel_c1 got %b exp 0", b_pixel); end
    @(negedge clk);
    checks++; if (b_fs !== 1'b1) begin errors++; $display("FAIL post_reset_fs got %b exp 1", b_fs); end
    checks++; if (b_pixel !== 1'b1) begin errors++; $display("FAIL post_reset_pixel got %b exp 1", b_pixel); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    invert  = 1'b0;
    test_reset();
    test_serialization();
    test_invert();
    test_line_timing();
    test_frame();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
